dff_bank_univ: RTL and testbench
================================

Name: dff_bank_univ

Overview:
- Parametrised successor to the single-bit flip-flop cells: a WIDTH-bit register bank with enable, synchronous set/reset, parallel load, shift, rotate and up/down count modes.
- Serves as the multi-bit storage/counter primitive for mapped designs in the cell library where a bank of flops plus mux logic would otherwise be built from discrete flops and gates.
- Single clock domain, fully synchronous.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).
- SET_VAL, all ones, value loaded into Q on synchronous set S (WIDTH bits).

Ports:
- C  input  1  clock; all state changes on rising edge.
- R  input  1  synchronous reset, active-low.
- S  input  1  synchronous set, active-high.
- E  input  1  enable for mode operations (does not gate R or S).
- M  input  3  mode select.
- D  input  WIDTH  parallel load data.
- SI  input  1  serial input for shift modes.
- Q  output  WIDTH  register contents.
- SO  output  1  registered bit shifted or rotated out on the last shift/rotate.
- CO  output  1  registered carry/borrow; one-cycle pulse on count wrap.

Behaviour:
- Priority at each rising C, highest first:
  - R==0: Q<=RESET_VAL, SO<=0, CO<=0.
  - else S==1: Q<=SET_VAL, SO<=0, CO<=0.
  - else E==0: Q and SO hold; CO<=0.
  - else the mode operation below.
- Reset values: Q=RESET_VAL, SO=0, CO=0.
- Mode encoding (E==1):
  - 000 hold: Q, SO unchanged.
  - 001 load: Q<=D.
  - 010 shift left: Q<={Q[WIDTH-2:0],SI}; SO<=Q[WIDTH-1].
  - 011 shift right: Q<={SI,Q[WIDTH-1:1]}; SO<=Q[0].
  - 100 count up: Q<=Q+1 mod 2^WIDTH; CO<=1 iff old Q==all ones.
  - 101 count down: Q<=Q-1 mod 2^WIDTH; CO<=1 iff old Q==0.
  - 110 rotate left: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; SO<=Q[WIDTH-1].
  - 111 rotate right: Q<={Q[0],Q[WIDTH-1:1]}; SO<=Q[0].
- SO changes only in shift/rotate modes (010, 011, 110, 111); it holds in all other modes.
- CO is 0 in every cycle that is not a wrapping count (single-cycle pulse); it never holds.
- Latency: one clock from inputs to Q/SO/CO; no combinational input-to-output path.
- Arithmetic is unsigned; wrap-around is silent apart from CO.
- Mode changes take effect on the very next edge; there is no internal state beyond Q, SO, CO.
- Reset or set asserted mid-count or mid-shift discards the operation in that cycle, including any CO pulse.
- X/Z on M while E==1 is outside the contract; the bench does not drive it.

Test Plan:
- WIDTH=8: R=0 for 2 cycles with S=1, E=1, M=001, D=8'hA5 → Q=8'h00, SO=0, CO=0. Confirms reset beats set and load.
- R=1, S=0, E=1, M=001, D=8'h3C → Q=8'h3C next edge. Then E=0, M=100 for 3 cycles → Q stays 8'h3C, CO=0.
- Load 8'hFD, then M=100 for 3 edges → Q=FE, FF, 00; CO=0,0,1. Switch to M=101 → Q=8'hFF with CO=1, then Q=8'hFE with CO=0.
- Load 8'b1000_0001, M=010 with SI=0 for 1 edge → Q=8'b0000_0010, SO=1. Then M=011 with SI=1 → Q=8'b1000_0001, SO=0.
- Load 8'h81, M=110 for 8 edges → Q returns to 8'h81; SO sequence 1,0,0,0,0,0,0,1. Repeat with M=111 → same final Q.
- During count-up from 8'hFF, assert S=1 on the wrap edge → Q=8'hFF (SET_VAL), CO=0. Repeat with R=0 on that edge → Q=8'h00, CO=0.

Source files
------------

// File: rtl/dff_bank_univ.sv
// rtl/dff_bank_univ.sv - WIDTH-bit register bank with load, shift, rotate and up/down count
//
// Ports:
//    C   clock, all state changes on the rising edge
//    R   synchronous reset, active-low (highest priority)
//    S   synchronous set, active-high
//    E   enable for mode operations (R and S are not gated by it)
//    M   mode select
//    D   parallel load data
//    SI  serial input for shift modes
//    Q   register contents
//    SO  registered bit shifted or rotated out on the last shift/rotate
//    CO  registered carry/borrow, one-cycle pulse on count wrap

module dff_bank_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
   input  logic             C,
   input  logic             R,
   input  logic             S,
   input  logic             E,
   input  logic [2:0]       M,
   input  logic [WIDTH-1:0] D,
   input  logic             SI,
   output logic [WIDTH-1:0] Q,
   output logic             SO,
   output logic             CO
);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_UP    = 3'b100,
      MODE_DOWN  = 3'b101,
      MODE_ROTL  = 3'b110,
      MODE_ROTR  = 3'b111
   } mode_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_next;
   logic             so_next;
   logic             co_next;
   mode_t            mode;

   assign mode = mode_t'(M);

   // Next state for an enabled cycle; priority over R/S/E is applied in the register.
   always_comb begin
      q_next  = Q;
      so_next = SO;
      co_next = 1'b0;
      case (mode)
         MODE_HOLD: begin
            q_next = Q;
         end
         MODE_LOAD: begin
            q_next = D;
         end
         MODE_SHL: begin
            q_next  = {Q[WIDTH-2:0], SI};
            so_next = Q[WIDTH-1];
         end
         MODE_SHR: begin
            q_next  = {SI, Q[WIDTH-1:1]};
            so_next = Q[0];
         end
         MODE_UP: begin
            q_next  = Q + ONE;
            co_next = &Q;
         end
         MODE_DOWN: begin
            q_next  = Q - ONE;
            co_next = ~|Q;
         end
         MODE_ROTL: begin
            q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
            so_next = Q[WIDTH-1];
         end
         MODE_ROTR: begin
            q_next  = {Q[0], Q[WIDTH-1:1]};
            so_next = Q[0];
         end
         default: begin
            q_next  = Q;
            so_next = SO;
            co_next = 1'b0;
         end
      endcase
   end

   // CO is cleared in every branch except a wrapping count so it can never hold.
   always_ff @(posedge C) begin
      if (!R) begin
         Q  <= RESET_VAL;
         SO <= 1'b0;
         CO <= 1'b0;
      end else if (S) begin
         Q  <= SET_VAL;
         SO <= 1'b0;
         CO <= 1'b0;
      end else if (!E) begin
         CO <= 1'b0;
      end else begin
         Q  <= q_next;
         SO <= so_next;
         CO <= co_next;
      end
   end

endmodule

// File: tb/tb_dff_bank_univ.sv
// tb/tb_dff_bank_univ.sv - directed self-checking bench for dff_bank_univ
module tb_dff_bank_univ;

   logic       C;
   logic       R;
   logic       S;
   logic       E;
   logic [2:0] M;
   logic [7:0] D;
   logic       SI;
   logic [7:0] Q;
   logic       SO;
   logic       CO;

   int n_checks;
   int n_fail;

   logic [7:0] rl_q [8];
   logic [7:0] rr_q [8];
   logic       so_exp;

   dff_bank_univ #(
      .WIDTH     (8),
      .RESET_VAL (8'h00),
      .SET_VAL   (8'hFF)
   ) dut (
      .C  (C),
      .R  (R),
      .S  (S),
      .E  (E),
      .M  (M),
      .D  (D),
      .SI (SI),
      .Q  (Q),
      .SO (SO),
      .CO (CO)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge C);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rl_q = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
      rr_q = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};

      // Reset beats set and load
      R = 1'b0; S = 1'b1; E = 1'b1; M = 3'b001; D = 8'hA5; SI = 1'b0;
      step();
      step();
      check("rst_q", Q, 8'h00);
      check("rst_so", SO, 1'b0);
      check("rst_co", CO, 1'b0);

      // Load then disabled count holds
      R = 1'b1; S = 1'b0; E = 1'b1; M = 3'b001; D = 8'h3C;
      step();
      check("load_3c", Q, 8'h3C);
      E = 1'b0; M = 3'b100;
      for (int i = 0; i < 3; i++) begin
         step();
         check("dis_q", Q, 8'h3C);
         check("dis_co", CO, 1'b0);
      end

      // Count up through wrap, then down through wrap
      E = 1'b1; M = 3'b001; D = 8'hFD;
      step();
      check("load_fd", Q, 8'hFD);
      M = 3'b100;
      step(); check("up1_q", Q, 8'hFE); check("up1_co", CO, 1'b0);
      step(); check("up2_q", Q, 8'hFF); check("up2_co", CO, 1'b0);
      step(); check("up3_q", Q, 8'h00); check("up3_co", CO, 1'b1);
      M = 3'b101;
      step(); check("dn1_q", Q, 8'hFF); check("dn1_co", CO, 1'b1);
      step(); check("dn2_q", Q, 8'hFE); check("dn2_co", CO, 1'b0);

      // Shift left then shift right
      M = 3'b001; D = 8'b1000_0001;
      step();
      M = 3'b010; SI = 1'b0;
      step();
      check("shl_q", Q, 8'b0000_0010);
      check("shl_so", SO, 1'b1);
      M = 3'b011; SI = 1'b1;
      step();
      check("shr_q", Q, 8'b1000_0001);
      check("shr_so", SO, 1'b0);

      // Rotate left 8 times
      M = 3'b001; D = 8'h81;
      step();
      M = 3'b110;
      for (int i = 0; i < 8; i++) begin
         step();
         so_exp = (i == 0 || i == 7);
         check("rotl_q", Q, rl_q[i]);
         check("rotl_so", SO, so_exp);
      end

      // Rotate right 8 times (load must not disturb SO)
      M = 3'b001; D = 8'h81;
      step();
      check("load_so_hold", SO, 1'b1);
      M = 3'b111;
      for (int i = 0; i < 8; i++) begin
         step();
         so_exp = (i == 0 || i == 7);
         check("rotr_q", Q, rr_q[i]);
         check("rotr_so", SO, so_exp);
      end

      // Enabled hold and count leave SO alone
      M = 3'b000;
      step();
      check("hold_q", Q, 8'h81);
      check("hold_so", SO, 1'b1);
      M = 3'b100;
      step();
      check("cnt_q", Q, 8'h82);
      check("cnt_so", SO, 1'b1);

      // Set on the wrap edge suppresses CO and clears SO
      M = 3'b001; D = 8'hFF;
      step();
      M = 3'b100; S = 1'b1;
      step();
      check("set_q", Q, 8'hFF);
      check("set_co", CO, 1'b0);
      check("set_so", SO, 1'b0);

      // Reset on the wrap edge
      S = 1'b0; R = 1'b0;
      step();
      check("rstw_q", Q, 8'h00);
      check("rstw_co", CO, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
